// File: rtl/des_round_ctrl.sv
// Iterative DES controller: IP/FP, PC-1/PC-2, key rotation, L/R rounds around an external combinational f block.
// Build option DES_CTRL_PIPE_F_EN registers f_res and splits each round into issue and commit cycles.
module des_round_ctrl #(
   parameter int unsigned ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   input  logic [63:0] in_data,
   input  logic [63:0] in_key,
   output logic [31:0] f_r,
   output logic [47:0] f_key,
   input  logic [31:0] f_res,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic [4:0]  round_idx
);

   localparam int unsigned BLK_W  = 64;
   localparam int unsigned HALF_W = 32;
   localparam int unsigned KEY_W  = 48;
   localparam int unsigned CD_W   = 56;
   localparam int unsigned RND_W  = 5;

   localparam int unsigned IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int unsigned FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int unsigned PC1_T [56] = '{
      57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
      63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int unsigned PC2_T [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_DONE = 2'd2} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_in_ready, r_out_valid, r_decrypt;
   logic [BLK_W-1:0]    r_out_data;
   logic [RND_W-1:0]    r_round;
   logic [HALF_W-1:0]   r_l, r_r;
   logic [CD_W-1:0]     r_cd;

   logic                w_accept, w_commit, w_out_hs, w_last, w_phase_ok;
   logic [1:0]          w_shift;
   logic [BLK_W-1:0]    w_ip, w_fp, w_pre;
   logic [CD_W-1:0]     w_pc1, w_cd_rot;
   logic [KEY_W-1:0]    w_key;
   logic [HALF_W-1:0]   w_f_bits, w_f_hex, w_r_nxt;
   logic                w_unused_parity;

   // C/D halves rotate independently; bit 1 of each half is its MSB
   function automatic logic [27:0] rot28(input logic [27:0] x, input logic right, input logic [1:0] sh);
      logic [27:0] y;
      y = x;
      case ({right, sh})
         3'b001:  y = {x[26:0], x[27]};
         3'b010:  y = {x[25:0], x[27:26]};
         3'b101:  y = {x[0], x[27:1]};
         3'b110:  y = {x[1:0], x[27:2]};
         default: y = x;
      endcase
      return y;
   endfunction

   // Fixed bit permutations (pure wiring)
   for (genvar g = 0; g < 64; g++) begin : g_ipfp
      assign w_ip[63-g] = in_data[64-IP_T[g]];
      assign w_fp[63-g] = w_pre[64-FP_T[g]];
   end
   for (genvar g = 0; g < 56; g++) begin : g_pc1
      assign w_pc1[55-g] = in_key[64-PC1_T[g]];
   end
   for (genvar g = 0; g < 48; g++) begin : g_pc2
      assign w_key[47-g] = w_cd_rot[56-PC2_T[g]];
      assign f_key[g]    = w_key[47-g];
   end
   for (genvar g = 0; g < 32; g++) begin : g_fbus
      assign f_r[g]     = r_r[31-g];
      assign w_f_hex[g] = w_f_bits[31-g];
   end

   assign w_unused_parity = ^{in_key[56], in_key[48], in_key[40], in_key[32],
                              in_key[24], in_key[16], in_key[8], in_key[0]};

`ifdef DES_CTRL_PIPE_F_EN
   logic              r_phase;
   logic [HALF_W-1:0] r_f_res;

   // Phase 0 issues f_r/f_key and captures f_res; phase 1 commits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= 1'b0;
         r_f_res <= '0;
      end else begin
         if (w_accept)
            r_phase <= 1'b0;
         else if (r_state == S_ROUND)
            r_phase <= ~r_phase;
         if (r_state == S_ROUND && !r_phase)
            r_f_res <= f_res;
      end
   end
   assign w_phase_ok = r_phase;
   assign w_f_bits   = r_f_res;
`else
   assign w_phase_ok = 1'b1;
   assign w_f_bits   = f_res;
`endif

   // Shift per round; decrypt walks the encrypt schedule backwards with round 1 unrotated
   always_comb begin
      w_shift = 2'd0;
      if (r_state == S_ROUND) begin
         if (r_decrypt && r_round == 5'd1)
            w_shift = 2'd0;
         else if ((!r_decrypt && r_round == 5'd1) || r_round == 5'd2 || r_round == 5'd9 || r_round == 5'd16)
            w_shift = 2'd1;
         else
            w_shift = 2'd2;
      end
   end

   assign w_cd_rot = {rot28(r_cd[55:28], r_decrypt, w_shift), rot28(r_cd[27:0], r_decrypt, w_shift)};
   assign w_r_nxt  = r_l ^ w_f_hex;
   assign w_pre    = {w_r_nxt, r_r};
   assign w_last   = (r_round == RND_W'(ROUNDS));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      w_out_hs    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid && r_in_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            w_commit = w_phase_ok;
            if (w_phase_ok && w_last)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (r_out_valid && out_ready) begin
               w_out_hs    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_round     <= '0;
         r_decrypt   <= 1'b0;
         r_l         <= '0;
         r_r         <= '0;
         r_cd        <= '0;
      end else begin
         r_in_ready <= (w_state_nxt == S_IDLE);
         if (w_accept) begin
            r_l       <= w_ip[63:32];
            r_r       <= w_ip[31:0];
            r_cd      <= w_pc1;
            r_decrypt <= in_decrypt;
            r_round   <= RND_W'(1);
         end
         if (w_commit) begin
            r_l  <= r_r;
            r_r  <= w_r_nxt;
            r_cd <= w_cd_rot;
            if (w_last) begin
               r_round     <= '0;
               r_out_data  <= w_fp;
               r_out_valid <= 1'b1;
            end else begin
               r_round <= r_round + RND_W'(1);
            end
         end
         if (w_out_hs)
            r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign round_idx = r_round;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: models the external f block and scoreboards DES known-answer vectors.
module tb_des_round_ctrl;

`ifdef DES_CTRL_PIPE_F_EN
   localparam int unsigned PIPE = 1;
`else
   localparam int unsigned PIPE = 0;
`endif
   localparam int unsigned LAT = (PIPE != 0) ? 33 : 17;

   localparam int unsigned E_T [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int unsigned P_T [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int unsigned SB [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   logic        clk, rst_n;
   logic        in_valid, in_ready, in_decrypt;
   logic [63:0] in_data, in_key;
   logic [31:0] f_r, f_res;
   logic [47:0] f_key;
   logic        out_valid, out_ready;
   logic [63:0] out_data;
   logic [4:0]  round_idx;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] sb [$];

   des_round_ctrl #(.ROUNDS(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt),
      .in_data(in_data), .in_key(in_key),
      .f_r(f_r), .f_key(f_key), .f_res(f_res),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .round_idx(round_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // f(R,K) = P(S(E(R) ^ K)), bit i of each bus is DES bit i+1
   function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s, res;
      logic [3:0]  v;
      int          row, col;
      for (int j = 0; j < 48; j++) x[j] = r[E_T[j] - 1] ^ k[j];
      for (int b = 0; b < 8; b++) begin
         row = 2 * int'(x[6*b]) + int'(x[6*b+5]);
         col = 8 * int'(x[6*b+1]) + 4 * int'(x[6*b+2]) + 2 * int'(x[6*b+3]) + int'(x[6*b+4]);
         v = 4'(SB[b*64 + row*16 + col]);
         s[4*b]   = v[3];
         s[4*b+1] = v[2];
         s[4*b+2] = v[1];
         s[4*b+3] = v[0];
      end
      for (int i = 0; i < 32; i++) res[i] = s[P_T[i] - 1];
      return res;
   endfunction

   always_comb f_res = f_model(f_r, f_key);

   function automatic logic [4:0] exp_round(input int k);
      return (PIPE != 0) ? 5'((k + 1) / 2) : 5'(k);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [63:0] d, input logic [63:0] k, input logic dec, input logic [63:0] exp);
      int n = 0;
      in_valid = 1'b1; in_data = d; in_key = k; in_decrypt = dec;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_wait", 64'(n < 50), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = {$urandom, $urandom}; in_decrypt = ~dec;
      sb.push_back(exp);
   endtask

   // Called in cycle T+1; tracks round_idx until out_valid and checks latency
   task automatic wait_result(input logic busy);
      int   k = 1;
      logic pulsed = 1'b0;
      while (out_valid !== 1'b1 && k <= int'(LAT) + 5) begin
         chk("round_idx", 64'(round_idx), 64'(exp_round(k)));
         chk("in_ready_busy", 64'(in_ready), 64'(0));
         if (busy && !pulsed && round_idx == 5'd5) begin
            in_valid = 1'b1; in_data = 64'hFEDCBA9876543210; in_key = 64'h0E329232EA6D0D73;
            pulsed = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1; k++;
      end
      in_valid = 1'b0;
      chk("latency", 64'(k), 64'(LAT));
   endtask

   task automatic drain(input int bp);
      logic [63:0] exp = '0;
      if (sb.size() > 0) exp = sb[0];
      chk("sb_not_empty", 64'(sb.size() > 0), 64'(1));
      for (int i = 0; i < bp; i++) begin
         chk("bp_out_valid", 64'(out_valid), 64'(1));
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_out_data", out_data, exp);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      chk("out_data", out_data, exp);
      if (sb.size() > 0) void'(sb.pop_front());
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("post_hs_out_valid", 64'(out_valid), 64'(0));
      chk("post_hs_in_ready", 64'(in_ready), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b0;
      in_data = '0; in_key = '0;
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_round_idx", 64'(round_idx), 64'(0));
      chk("rst_f_r", 64'(f_r), 64'(0));
      chk("rst_f_key", 64'(f_key), 64'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 64'(in_ready), 64'(1));

      send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
      wait_result(1'b0);
      drain(0);

      send(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 1'b1, 64'h0123456789ABCDEF);
      wait_result(1'b0);
      drain(0);

      send(64'h8787878787878787, 64'h0E329232EA6D0D73, 1'b0, 64'h0000000000000000);
      wait_result(1'b0);
      drain(0);

      send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
      wait_result(1'b0);
      drain(10);

      send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
      wait_result(1'b1);
      drain(2);

      // Abort mid-block with async reset; the aborted block must never emerge
      send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
      n = 0;
      while (round_idx !== 5'd8 && n < 60) begin
         @(posedge clk); #1; n++;
      end
      chk("abort_reach_r8", 64'(n < 60), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 64'(out_valid), 64'(0));
      chk("abort_in_ready", 64'(in_ready), 64'(0));
      chk("abort_round_idx", 64'(round_idx), 64'(0));
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("abort_idle_out_valid", 64'(out_valid), 64'(0));
         chk("abort_idle_in_ready", 64'(in_ready), 64'(1));
      end

      send(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 1'b0, 64'h85E813540F0AB405);
      wait_result(1'b0);
      drain(0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
